// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder with a wrapping position counter.
// Phases A/B are synchronised, glitch-filtered and Gray-decoded into
// up/down steps. An ARM window after reset copies the idle pin levels into
// the decoder so that pins idling at any state never raise a false error.
module quad_decoder #(
  parameter int COUNT_WIDTH = 8,
  parameter int FILTER_LEN  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   quad_a,
  input  logic                   quad_b,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   step,
  output logic                   dir,
  output logic                   err
);

  // Filter counter only needs to reach FILTER_LEN-1.
  localparam int FW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  // ARM covers the synchroniser plus one full filter window.
  localparam int ARM_LEN = 2 + FILTER_LEN;
  localparam int AW      = $clog2(ARM_LEN);

  typedef enum logic {
    ARM = 1'b0,
    RUN = 1'b1
  } state_t;

  state_t state, state_nx;

  // Phase vectors: bit 1 is A, bit 0 is B, so {a,b} reads naturally.
  logic [1:0]    s1, s2;
  logic [1:0]    filt;
  logic [1:0]    prev;
  logic [FW-1:0] flt_cnt [2];
  logic [AW-1:0] arm_cnt;

  logic arm_done;
  logic is_step;
  logic is_up;
  logic is_illegal;

  assign arm_done = (arm_cnt == AW'(ARM_LEN - 1));

  // FSM state register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers sample pre-edge values and simulation matches the netlist.
  always_ff @(posedge clk) begin
    if (rst) state <= ARM;
    else     state <= state_nx;
  end

  // Next-state and step decode from the previous to the filtered phases.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    is_step    = 1'b0;
    is_up      = 1'b0;
    is_illegal = 1'b0;
    case (state)
      ARM: begin
        if (arm_done) state_nx = RUN;
      end
      RUN: begin
        // Exactly one phase moved: a legal Gray step. In both cases the
        // direction is up exactly when the new A differs from the old B.
        is_step    = ((prev ^ filt) == 2'b10) || ((prev ^ filt) == 2'b01);
        is_up      = filt[1] ^ prev[0];
        is_illegal = ((prev ^ filt) == 2'b11);
      end
      default: state_nx = ARM;
    endcase
  end

  // ARM window length counter; parks once the window has elapsed.
  always_ff @(posedge clk) begin
    if (rst)                          arm_cnt <= '0;
    else if (state == ARM && !arm_done) arm_cnt <= arm_cnt + 1'b1;
  end

  // Two-flop synchroniser for both asynchronous phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {quad_a, quad_b};
      s2 <= s1;
    end
  end

  // Per-phase glitch filter: a new level must persist FILTER_LEN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (state == ARM) begin
          filt[i]    <= s2[i];
          flt_cnt[i] <= '0;
        end else if (s2[i] != filt[i]) begin
          if (flt_cnt[i] == FW'(FILTER_LEN - 1)) begin
            filt[i]    <= s2[i];
            flt_cnt[i] <= '0;
          end else begin
            flt_cnt[i] <= flt_cnt[i] + 1'b1;
          end
        end else begin
          flt_cnt[i] <= '0;
        end
      end
    end
  end

  // Previous decoded phases; tracks s2 while arming, filt while running.
  // Updates even under clear so the step after a clear decodes correctly.
  always_ff @(posedge clk) begin
    if (rst)                prev <= '0;
    else if (state == ARM)  prev <= s2;
    else                    prev <= filt;
  end

  // Position counter, step pulse, direction and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_out <= '0;
      step      <= 1'b0;
      dir       <= 1'b0;
      err       <= 1'b0;
    end else begin
      step <= 1'b0;
      if (clear) begin
        // Clear wins over a same-cycle step or illegal transition.
        count_out <= '0;
        err       <= 1'b0;
      end else begin
        if (is_step) begin
          step      <= 1'b1;
          dir       <= is_up;
          count_out <= is_up ? count_out + COUNT_WIDTH'(1)
                             : count_out - COUNT_WIDTH'(1);
        end
        if (is_illegal) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder: directed scenarios plus a random Gray walk,
// checked against a position model built on quadrature phase arithmetic.
module tb_quad_decoder;

  localparam int CW = 8;
  localparam int FL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          quad_a;
  logic          quad_b;
  logic          clear;
  logic [CW-1:0] count_out;
  logic          step;
  logic          dir;
  logic          err;

  int errors = 0;
  int checks = 0;

  // Step pulse monitor: counts pulses and pulses wider than one cycle.
  int   pulse_total = 0;
  int   wide_pulses = 0;
  logic step_d      = 1'b0;

  // Reference model state.
  int         m_count;
  logic       m_dir;
  logic       m_err;
  logic [1:0] m_ab;
  int         m_pulses;
  int         pulse_base;

  quad_decoder #(.COUNT_WIDTH(CW), .FILTER_LEN(FL)) dut (
    .clk       (clk),
    .rst       (rst),
    .quad_a    (quad_a),
    .quad_b    (quad_b),
    .clear     (clear),
    .count_out (count_out),
    .step      (step),
    .dir       (dir),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step) pulse_total <= pulse_total + 1;
    if (step && step_d) wide_pulses <= wide_pulses + 1;
    step_d <= step;
  end

  // Position of a phase pair along the up sequence 00,10,11,01.
  function automatic int gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] pos_to_ab(input int p);
    logic [1:0] lut [4];
    lut = '{2'b00, 2'b10, 2'b11, 2'b01};
    return lut[p % 4];
  endfunction

  // Advance the model by one pin move: +1 position is up, -1 is down,
  // +2 means both phases flipped together.
  task automatic model_move(input logic [1:0] ab);
    int d;
    d = (gray_pos(ab) - gray_pos(m_ab) + 4) % 4;
    if (d == 1) begin
      m_count  = (m_count + 1) % (1 << CW);
      m_dir    = 1'b1;
      m_pulses = m_pulses + 1;
    end else if (d == 3) begin
      m_count  = (m_count + (1 << CW) - 1) % (1 << CW);
      m_dir    = 1'b0;
      m_pulses = m_pulses + 1;
    end else if (d == 2) begin
      m_err = 1'b1;
    end
    m_ab = ab;
  endtask

  task automatic drive(input logic [1:0] ab);
    @(posedge clk);
    #1;
    {quad_a, quad_b} = ab;
  endtask

  task automatic apply(input logic [1:0] ab, input int hold);
    drive(ab);
    model_move(ab);
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear = 1'b0;
    {quad_a, quad_b} = ab;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_count = 0; m_dir = 1'b0; m_err = 1'b0; m_ab = ab; m_pulses = 0;
    repeat (12) @(posedge clk);
    #1;
    pulse_base = pulse_total;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; quad_a = 1'b1; quad_b = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (count_out !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_out); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b expected 0", dir); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    m_count = 0; m_dir = 1'b0; m_err = 1'b0; m_ab = 2'b11; m_pulses = 0;
    pulse_base = pulse_total;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL arm_err: got %b expected 0", err); end
    checks++; if (count_out !== '0) begin errors++; $display("FAIL arm_count: got %0d expected 0", count_out); end
    checks++; if (pulse_total - pulse_base != 0) begin errors++; $display("FAIL arm_pulses: got %0d expected 0", pulse_total - pulse_base); end
  endtask

  task automatic test_up_down();
    logic [1:0] up_seq [4];
    logic [1:0] dn_seq [4];
    up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    dn_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset(2'b00);
    foreach (up_seq[i]) begin
      apply(up_seq[i], 8);
      #1;
      checks++; if (count_out !== m_count[CW-1:0]) begin errors++; $display("FAIL up_count[%0d]: got %0d expected %0d", i, count_out, m_count); end
    end
    settle();
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL up_dir: got %b expected 1", dir); end
    checks++; if (pulse_total - pulse_base != 4) begin errors++; $display("FAIL up_pulses: got %0d expected 4", pulse_total - pulse_base); end
    foreach (dn_seq[i]) begin
      apply(dn_seq[i], 8);
      #1;
      checks++; if (count_out !== m_count[CW-1:0]) begin errors++; $display("FAIL down_count[%0d]: got %0d expected %0d", i, count_out, m_count); end
    end
    settle();
    checks++; if (count_out !== '0) begin errors++; $display("FAIL down_final: got %0d expected 0", count_out); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL down_dir: got %b expected 0", dir); end
    checks++; if (pulse_total - pulse_base != m_pulses) begin errors++; $display("FAIL down_pulses: got %0d expected %0d", pulse_total - pulse_base, m_pulses); end
  endtask

  task automatic test_wrap();
    apply(2'b01, 8);
    settle();
    checks++; if (count_out !== 8'd255) begin errors++; $display("FAIL wrap_down: got %0d expected 255", count_out); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL wrap_down_dir: got %b expected 0", dir); end
    apply(2'b00, 8);
    settle();
    checks++; if (count_out !== 8'd0) begin errors++; $display("FAIL wrap_up: got %0d expected 0", count_out); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL wrap_up_dir: got %b expected 1", dir); end
  endtask

  task automatic test_glitch();
    int base;
    base = pulse_total;
    // A high for FILTER_LEN-1 cycles: must be rejected.
    drive(2'b10);
    repeat (FL - 2) @(posedge clk);
    drive(2'b00);
    settle();
    checks++; if (count_out !== m_count[CW-1:0]) begin errors++; $display("FAIL glitch_count: got %0d expected %0d", count_out, m_count); end
    checks++; if (pulse_total - base != 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulse_total - base); end
    // A rises and stays for FILTER_LEN cycles and beyond: one step.
    apply(2'b10, FL);
    settle();
    checks++; if (count_out !== m_count[CW-1:0]) begin errors++; $display("FAIL pulse3_count: got %0d expected %0d", count_out, m_count); end
    checks++; if (pulse_total - base != 1) begin errors++; $display("FAIL pulse3_pulses: got %0d expected 1", pulse_total - base); end
    apply(2'b00, 8);
    settle();
  endtask

  task automatic test_illegal();
    apply(2'b11, 8);
    settle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", err); end
    checks++; if (count_out !== m_count[CW-1:0]) begin errors++; $display("FAIL illegal_count: got %0d expected %0d", count_out, m_count); end
    apply(2'b01, 8);
    apply(2'b00, 8);
    settle();
    checks++; if (count_out !== m_count[CW-1:0]) begin errors++; $display("FAIL after_illegal_count: got %0d expected %0d", count_out, m_count); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    m_count = 0; m_err = 1'b0;
    checks++; if (count_out !== '0) begin errors++; $display("FAIL clear_count: got %0d expected 0", count_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b expected 0", err); end
    checks++; if (dir !== m_dir) begin errors++; $display("FAIL clear_dir_hold: got %b expected %b", dir, m_dir); end
    // Clear on the same cycle the illegal move is decoded: clear wins.
    drive(2'b11);
    repeat (5) @(posedge clk);
    #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    m_ab = 2'b11;
    settle();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_vs_illegal: got %b expected 0", err); end
    apply(2'b01, 8);
    apply(2'b00, 8);
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    m_count = 0;
  endtask

  task automatic test_clear_step();
    int base;
    base = pulse_total;
    // Up step 00->10 whose decode edge coincides with clear.
    drive(2'b10);
    repeat (5) @(posedge clk);
    #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    m_ab = 2'b10;
    checks++; if (count_out !== '0) begin errors++; $display("FAIL clear_step_count: got %0d expected 0", count_out); end
    settle();
    checks++; if (pulse_total - base != 0) begin errors++; $display("FAIL clear_step_pulse: got %0d expected 0", pulse_total - base); end
    apply(2'b11, 8);
    settle();
    checks++; if (count_out !== 8'd1) begin errors++; $display("FAIL post_clear_step: got %0d expected 1", count_out); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL post_clear_dir: got %b expected 1", dir); end
  endtask

  task automatic test_rst_mid();
    apply(2'b01, 8);
    settle();
    drive(2'b00);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (count_out !== '0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count_out); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL midrst_step: got %b expected 0", step); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL midrst_dir: got %b expected 0", dir); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", err); end
    repeat (4) @(posedge clk);
    #1; rst = 1'b0;
    m_count = 0; m_dir = 1'b0; m_err = 1'b0; m_ab = 2'b00; m_pulses = 0;
    pulse_base = pulse_total;
    settle();
    checks++; if (count_out !== '0) begin errors++; $display("FAIL postrst_count: got %0d expected 0", count_out); end
    checks++; if (pulse_total - pulse_base != 0) begin errors++; $display("FAIL postrst_pulses: got %0d expected 0", pulse_total - pulse_base); end
  endtask

  task automatic test_random_walk();
    int p;
    int r;
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      p = gray_pos(m_ab);
      if (r < 5)      p = (p + 1) % 4;
      else if (r < 9) p = (p + 3) % 4;
      apply(pos_to_ab(p), int'($urandom_range(FL + 1, 10)));
      if (n % 10 == 9) begin
        settle();
        checks++; if (count_out !== m_count[CW-1:0]) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, count_out, m_count); end
        checks++; if (dir !== m_dir) begin errors++; $display("FAIL rand_dir[%0d]: got %b expected %b", n, dir, m_dir); end
        checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", n, err, m_err); end
        checks++; if (pulse_total - pulse_base != m_pulses) begin errors++; $display("FAIL rand_pulses[%0d]: got %0d expected %0d", n, pulse_total - pulse_base, m_pulses); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_down();
    test_wrap();
    test_glitch();
    test_illegal();
    test_clear_step();
    test_rst_mid();
    test_random_walk();
    checks++; if (wide_pulses != 0) begin errors++; $display("FAIL step_width: got %0d wide pulses expected 0", wide_pulses); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
